// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - requester/display bundle for seg_display_arbiter
interface seg_display_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     upd;
  logic [NREQ*4*N-1:0] data_in;
  logic [NREQ-1:0]     grant;
  logic [2:0]          owner;
  logic [NREQ-1:0]     done;
  logic [4*N-1:0]      din_out;
  logic                blank;

  modport master (
    output req, upd, data_in,
    input  grant, owner, done, din_out, blank
  );

  modport slave (
    input  req, upd, data_in,
    output grant, owner, done, din_out, blank
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin, min-dwell owner arbiter for a shared seven-segment display
module seg_display_arbiter #(
  parameter int N     = 4,
  parameter int NREQ  = 3,
  parameter int DWELL = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_arbiter_if.slave bus
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int W  = 4 * N;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    din_q, din_d;
  logic            blank_q, blank_d;

  logic       found;
  logic [2:0] win;
  int         idx;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    din_d   = din_q;
    blank_d = blank_q;

    if (state_q == SHOW && cnt_q != CW'(DWELL - 1)) begin
      cnt_d = cnt_q + 1'b1;
      if (bus.upd[owner_q]) din_d = bus.data_in[W*owner_q +: W];
    end else begin
      if (state_q == SHOW) done_d = NREQ'(1) << owner_q;
      if (found) begin
        state_d = SHOW;
        grant_d = NREQ'(1) << win;
        owner_d = win;
        din_d   = bus.data_in[W*win +: W];
        blank_d = 1'b0;
        cnt_d   = '0;
        ptr_d   = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        blank_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      din_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      din_q   <= din_d;
      blank_q <= blank_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.done    = done_q;
  assign bus.din_out = din_q;
  assign bus.blank   = blank_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - randomized bench against a cycle-level ownership model
module tb_seg_display_arbiter;
  localparam int N     = 4;
  localparam int NREQ  = 3;
  localparam int DWELL = 8;
  localparam int W     = 4 * N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_display_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  seg_display_arbiter #(.N(N), .NREQ(NREQ), .DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: who owns the display and how many cycles it has held it.
  int          m_own;
  int          m_age;
  int          m_ptr;
  int          m_owner;
  logic [31:0] m_done;
  logic [31:0] m_din;
  logic        m_blank;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] slice(input logic [NREQ*W-1:0] d, input int i);
    logic [31:0] s;
    s = 32'(d[W*i +: W]);
    return s;
  endfunction

  task automatic model_edge(input logic r, input logic [NREQ-1:0] rq,
                            input logic [NREQ-1:0] up, input logic [NREQ*W-1:0] d);
    int w;
    if (r) begin
      m_own = -1; m_age = 0; m_ptr = 0; m_owner = 0;
      m_done = 0; m_din = 0; m_blank = 1'b1;
      return;
    end
    m_done = 0;
    if (m_own >= 0 && m_age < DWELL) begin
      m_age++;
      if (up[m_own]) m_din = slice(d, m_own);
    end else begin
      if (m_own >= 0) m_done = 32'(1) << m_own;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && rq[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_own = w; m_owner = w; m_age = 1; m_blank = 1'b0;
        m_din = slice(d, w);
        m_ptr = (w + 1) % NREQ;
      end else begin
        m_own = -1; m_blank = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] rq,
                      input logic [NREQ-1:0] up, input logic [NREQ*W-1:0] d);
    logic [31:0] eg;
    reset       = r;
    bus.req     = rq;
    bus.upd     = up;
    bus.data_in = d;
    @(posedge clk);
    model_edge(r, rq, up, d);
    #1;
    eg = (m_own < 0) ? 32'd0 : (32'(1) << m_own);
    check("grant",   32'(bus.grant),   eg);
    check("owner",   32'(bus.owner),   32'(m_owner));
    check("done",    32'(bus.done),    m_done);
    check("din_out", 32'(bus.din_out), m_din);
    check("blank",   32'(bus.blank),   32'(m_blank));
  endtask

  logic [NREQ*W-1:0] d;
  logic [NREQ-1:0]   rq;
  logic [NREQ-1:0]   up;

  initial begin
    m_own = -1; m_age = 0; m_ptr = 0; m_owner = 0;
    m_done = 0; m_din = 0; m_blank = 1'b1;
    d = {16'h3333, 16'h2222, 16'h1111};

    // Reset with all requesting, then release.
    step(1'b1, 3'b111, 3'b000, d);
    step(1'b1, 3'b111, 3'b000, d);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_blank", 32'(bus.blank), 32'd1);
    step(1'b0, 3'b111, 3'b000, d);
    check("first_grant", 32'(bus.grant), 32'b001);

    // Round-robin with everyone requesting.
    for (int c = 0; c < 4 * DWELL; c++) step(1'b0, 3'b111, 3'b000, d);

    // Single requester, drops req early, then idle.
    step(1'b1, 3'b000, 3'b000, d);
    d[15:0] = 16'h1234;
    for (int c = 0; c < 14; c++) step(1'b0, (c < 3) ? 3'b001 : 3'b000, 3'b000, d);
    check("idle_din", 32'(bus.din_out), 32'h1234);

    // Sole requester re-grant with silent data change.
    d[47:32] = 16'h0009;
    for (int c = 0; c < 3 * DWELL; c++) begin
      if (c == 5) d[47:32] = 16'h0010;
      step(1'b0, 3'b100, 3'b000, d);
    end

    // Randomized traffic with occasional updates and resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) rq = NREQ'($urandom);
      up = NREQ'($urandom) & NREQ'({3{$urandom_range(0, 3) == 0}});
      if ($urandom_range(0, 2) == 0) d = NREQ*W'({$urandom, $urandom});
      step(($urandom_range(0, 150) == 0), rq, up, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rq = '0;
    up = '0;
  end
endmodule
